reservation_station: RTL
========================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning): RS_DEPTH, 4, entry count (power of two, >=2); MAX_OPERANDS, 3, operand slots; PRN_BITS, 6, physical register width; INST_ID_BITS, 6, ROB id width; FU_COUNT, 4, functional units; FU_INDEX, 0, FU this station serves.
REQ-002 The block SHALL have one clock, clk, and reset rst, asynchronous and active-high; the ports are (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- in_valid  in  1  renamed instruction present
- in_inst_id  in  INST_ID_BITS  ROB id
- in_raw_instr  in  32  instruction word
- in_instr_pc  in  64  PC
- in_fu_choice  in  FUC_BITS  target FU
- in_prn_input_valid / in_prn_input_ready  in  1 x MAX_OPERANDS  source used / already ready
- in_prn_input  in  PRN_BITS x MAX_OPERANDS  source PRNs
- in_prn_output_valid  in  1 x MAX_OPERANDS  destination used
- in_prn_output  in  PRN_BITS x MAX_OPERANDS  destination PRNs
- set_prn_ready_valid  in  1 x FU_COUNT x MAX_OPERANDS  wakeup strobes
- set_prn_ready  in  PRN_BITS x FU_COUNT x MAX_OPERANDS  wakeup PRNs
- flush  in  1  squash all entries
- fu_ready  in  1  FU accepts issue this cycle
- stall_rename  out  1  combinational backpressure
- issue_valid  out  1  registered issue present
- issue_inst_id, issue_raw_instr, issue_instr_pc, issue_prn_input, issue_prn_output_valid, issue_prn_output  out  as inputs  issued instruction fields
- occupancy  out  clog2(RS_DEPTH)+1  valid entry count

Function
REQ-003 Accept SHALL occur when in_valid, in_fu_choice==FU_INDEX, at least one free entry, and !flush; the instruction is written at the rising edge into the lowest-indexed free entry.
REQ-004 stall_rename SHALL equal in_valid && in_fu_choice==FU_INDEX && all entries valid; an entry freed by issue in the same cycle SHALL NOT be counted as free.
REQ-005 Instructions with in_fu_choice!=FU_INDEX SHALL be ignored and SHALL NOT raise stall_rename.
REQ-006 Per operand, stored ready SHALL be set if !in_prn_input_valid, or in_prn_input_ready, or the PRN matches any asserted wakeup strobe in the accept cycle (same-cycle bypass).
REQ-007 Each cycle, every valid entry operand whose PRN matches any asserted set_prn_ready strobe SHALL set its ready bit at the edge; ready bits never clear while the entry is valid.
REQ-008 An entry SHALL be eligible when valid and all operand ready bits are set (stored values only; a wakeup affects eligibility from the next cycle).
REQ-009 Each entry SHALL hold an age of clog2(RS_DEPTH) bits: new entries get 0, and every other valid entry increments by 1 on each accept, saturating at RS_DEPTH-1.
REQ-010 Selection SHALL pick the eligible entry with the largest age, ties to the lowest index.
REQ-011 When issue_valid==0 or fu_ready==1 and an entry is eligible, the selected entry SHALL be loaded into the issue register and invalidated at the same edge; otherwise the issue register SHALL hold.
REQ-012 When issue_valid==1 and fu_ready==0, issue outputs SHALL stay stable; issue_valid SHALL drop only after a fu_ready handshake with nothing eligible.
REQ-013 Minimum latency SHALL be one cycle: an accepted, fully ready instruction appears on issue_valid at the edge after the one that stored it.
REQ-014 flush SHALL invalidate all entries and clear issue_valid at the next edge, overriding accept and issue in that cycle.
REQ-015 occupancy SHALL equal the registered count of valid entries.

Reset
REQ-016 While rst is high, all entries, ready bits, ages, issue_valid, issue fields and occupancy SHALL be 0 immediately, regardless of clk; stall_rename SHALL follow REQ-004 with empty state (0).
REQ-017 Reset asserted mid-operation SHALL discard all entries and any pending issue without a handshake.

Structure
REQ-018 FUC_BITS = $clog2(FU_COUNT) and the issue-packet struct (id, instr, pc, PRNs, valids) SHALL be defined in the shared foxtrot_pkg package.
REQ-019 The oldest-ready picker SHALL be a separate combinational sub-module, rs_select, taking eligible and age vectors and returning a one-hot grant and valid flag.

Verification
REQ-020 The bench SHALL cover:
- Ready instr (FU match, all sources ready, id=5) accepted at edge 1 -> issue_valid=1, issue_inst_id=5 after edge 2.
- Source PRN 12 not ready; wakeup set_prn_ready[2][0]=12 three cycles later -> issue one cycle after the wakeup edge.
- Four accepted, none ready -> fifth in_valid gives stall_rename=1, occupancy=4; wake all -> issue order ids match accept order.
- fu_ready=0 for 3 cycles with issue_valid=1 -> outputs stable; fu_ready=1 -> next eligible entry loaded the following edge.
- Wakeup in same cycle as accept of source PRN 7 -> entry stored ready and issues next cycle.
- flush (and separately rst pulse between edges) with 3 entries -> occupancy=0, issue_valid=0 immediately after edge (rst: asynchronously).

Source files
------------

// File: rtl/foxtrot_pkg.sv
// Shared definitions for the foxtrot out-of-order core slice.
//   FUC_BITS     : width of a functional-unit selector
//   issue_pkt_t  : instruction fields carried from a reservation station
//                  entry to its functional unit (id, word, PC, source PRNs,
//                  destination valids and PRNs)
// The *_DEF constants size issue_pkt_t and are the parameter defaults of
// the blocks that use it, so both stay consistent.
package foxtrot_pkg;

  localparam int RS_DEPTH_DEF     = 4;
  localparam int MAX_OPERANDS_DEF = 3;
  localparam int PRN_BITS_DEF     = 6;
  localparam int INST_ID_BITS_DEF = 6;
  localparam int FU_COUNT_DEF     = 4;

  localparam int FUC_BITS = $clog2(FU_COUNT_DEF);

  typedef struct packed {
    logic [INST_ID_BITS_DEF-1:0]                     inst_id;
    logic [31:0]                                     raw_instr;
    logic [63:0]                                     instr_pc;
    logic [MAX_OPERANDS_DEF-1:0][PRN_BITS_DEF-1:0]   prn_input;
    logic [MAX_OPERANDS_DEF-1:0]                     prn_output_valid;
    logic [MAX_OPERANDS_DEF-1:0][PRN_BITS_DEF-1:0]   prn_output;
  } issue_pkt_t;

endpackage

// File: rtl/rs_select.sv
// Oldest-ready picker for the reservation station (purely combinational).
//   eligible : per-entry "ready to issue" flags
//   age      : per-entry age, larger is older
//   grant    : one-hot selection of the oldest eligible entry
//   valid    : at least one entry is eligible
// Ties in age go to the lowest index because only a strictly larger age
// replaces the current winner while scanning upward.
module rs_select #(
  parameter int N     = 4,
  parameter int AGE_W = 2
) (
  input  logic [N-1:0]            eligible,
  input  logic [N-1:0][AGE_W-1:0] age,
  output logic [N-1:0]            grant,
  output logic                    valid
);

  logic [AGE_W-1:0] best_age;

  always_comb begin
    grant    = '0;
    valid    = 1'b0;
    best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i] && (!valid || (age[i] > best_age))) begin
        grant    = '0;
        grant[i] = 1'b1;
        valid    = 1'b1;
        best_age = age[i];
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for one functional unit.
// Renamed instructions targeting FU_INDEX are stored in the lowest free
// entry, wait until all source PRNs are ready (via wakeup broadcasts), and
// the oldest ready entry is moved into a registered issue slot held until
// the FU handshakes with fu_ready.
// Ports:
//   clk, rst                     clock, async active-high reset
//   in_*                         renamed instruction from rename
//   set_prn_ready_valid/_ready   wakeup broadcast [fu][slot]
//   flush                        squash all entries and the issue slot
//   fu_ready                     FU accepts the issue slot this cycle
//   stall_rename                 combinational backpressure to rename
//   issue_*                      registered issue slot
//   occupancy                    registered count of valid entries
module reservation_station
  import foxtrot_pkg::*;
#(
  parameter int RS_DEPTH     = RS_DEPTH_DEF,
  parameter int MAX_OPERANDS = MAX_OPERANDS_DEF,
  parameter int PRN_BITS     = PRN_BITS_DEF,
  parameter int INST_ID_BITS = INST_ID_BITS_DEF,
  parameter int FU_COUNT     = FU_COUNT_DEF,
  parameter int FU_INDEX     = 0
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  input  logic [INST_ID_BITS-1:0]                          in_inst_id,
  input  logic [31:0]                                      in_raw_instr,
  input  logic [63:0]                                      in_instr_pc,
  input  logic [FUC_BITS-1:0]                              in_fu_choice,
  input  logic [MAX_OPERANDS-1:0]                          in_prn_input_valid,
  input  logic [MAX_OPERANDS-1:0]                          in_prn_input_ready,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            in_prn_input,
  input  logic [MAX_OPERANDS-1:0]                          in_prn_output_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            in_prn_output,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]            set_prn_ready_valid,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn_ready,
  input  logic                                             flush,
  input  logic                                             fu_ready,
  output logic                                             stall_rename,
  output logic                                             issue_valid,
  output logic [INST_ID_BITS-1:0]                          issue_inst_id,
  output logic [31:0]                                      issue_raw_instr,
  output logic [63:0]                                      issue_instr_pc,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            issue_prn_input,
  output logic [MAX_OPERANDS-1:0]                          issue_prn_output_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            issue_prn_output,
  output logic [$clog2(RS_DEPTH):0]                        occupancy
);

  localparam int AGE_W = $clog2(RS_DEPTH);
  localparam int OCC_W = AGE_W + 1;
  localparam logic [AGE_W-1:0]    AGE_MAX = AGE_W'(RS_DEPTH - 1);
  localparam logic [FUC_BITS-1:0] FU_SEL  = FUC_BITS'(FU_INDEX);

  logic [RS_DEPTH-1:0]                   ent_valid;
  logic [RS_DEPTH-1:0][MAX_OPERANDS-1:0] ent_rdy;
  logic [RS_DEPTH-1:0][AGE_W-1:0]        ent_age;
  issue_pkt_t                            ent_pkt [RS_DEPTH];
  issue_pkt_t                            issue_pkt;

  logic [RS_DEPTH-1:0][MAX_OPERANDS-1:0] ent_wake;
  logic [MAX_OPERANDS-1:0]               in_wake;
  logic [MAX_OPERANDS-1:0]               in_rdy_new;
  logic [RS_DEPTH-1:0]                   eligible;
  logic [RS_DEPTH-1:0]                   grant;
  logic                                  sel_valid;
  logic [AGE_W-1:0]                      sel_idx;
  logic [AGE_W-1:0]                      alloc_idx;
  logic                                  has_free;
  logic                                  fu_match;
  logic                                  accept;
  logic                                  do_issue;
  issue_pkt_t                            in_pkt;

  // Wakeup match: every broadcast is compared against every stored source
  // and against the incoming sources (same-cycle bypass into the new entry).
  always_comb begin
    ent_wake = '0;
    in_wake  = '0;
    for (int f = 0; f < FU_COUNT; f++) begin
      for (int s = 0; s < MAX_OPERANDS; s++) begin
        if (set_prn_ready_valid[f][s]) begin
          for (int o = 0; o < MAX_OPERANDS; o++) begin
            if (in_prn_input[o] == set_prn_ready[f][s]) in_wake[o] = 1'b1;
            for (int i = 0; i < RS_DEPTH; i++) begin
              if (ent_pkt[i].prn_input[o] == set_prn_ready[f][s]) ent_wake[i][o] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    in_rdy_new = ~in_prn_input_valid | in_prn_input_ready | in_wake;
    in_pkt.inst_id          = in_inst_id;
    in_pkt.raw_instr        = in_raw_instr;
    in_pkt.instr_pc         = in_instr_pc;
    in_pkt.prn_input        = in_prn_input;
    in_pkt.prn_output_valid = in_prn_output_valid;
    in_pkt.prn_output       = in_prn_output;
  end

  // Lowest-indexed free entry; scanning downward leaves the lowest one.
  // An entry issuing this cycle is still valid here, so it is not free.
  always_comb begin
    has_free  = 1'b0;
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        has_free  = 1'b1;
        alloc_idx = AGE_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      eligible[i] = ent_valid[i] && (&ent_rdy[i]);
    end
  end

  rs_select #(
    .N     (RS_DEPTH),
    .AGE_W (AGE_W)
  ) u_select (
    .eligible (eligible),
    .age      (ent_age),
    .grant    (grant),
    .valid    (sel_valid)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant[i]) sel_idx = AGE_W'(i);
    end
  end

  assign fu_match     = (in_fu_choice == FU_SEL);
  assign stall_rename = in_valid && fu_match && !has_free;
  assign accept       = in_valid && fu_match && has_free && !flush;
  assign do_issue     = sel_valid && (!issue_valid || fu_ready) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid   <= '0;
      ent_rdy     <= '0;
      ent_age     <= '0;
      for (int i = 0; i < RS_DEPTH; i++) ent_pkt[i] <= '0;
      issue_pkt   <= '0;
      issue_valid <= 1'b0;
      occupancy   <= '0;
    end else if (flush) begin
      ent_valid   <= '0;
      issue_valid <= 1'b0;
      occupancy   <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (ent_valid[i]) begin
          ent_rdy[i] <= ent_rdy[i] | ent_wake[i];
          if (accept && (ent_age[i] != AGE_MAX)) ent_age[i] <= ent_age[i] + 1'b1;
          if (do_issue && grant[i]) ent_valid[i] <= 1'b0;
        end
      end
      if (accept) begin
        ent_valid[alloc_idx] <= 1'b1;
        ent_rdy[alloc_idx]   <= in_rdy_new;
        ent_age[alloc_idx]   <= '0;
        ent_pkt[alloc_idx]   <= in_pkt;
      end
      // The issue slot holds while the FU stalls; it empties only on a
      // handshake with nothing eligible to replace it.
      if (do_issue) begin
        issue_pkt   <= ent_pkt[sel_idx];
        issue_valid <= 1'b1;
      end else if (fu_ready) begin
        issue_valid <= 1'b0;
      end
      occupancy <= occupancy + OCC_W'(accept) - OCC_W'(do_issue);
    end
  end

  assign issue_inst_id          = issue_pkt.inst_id;
  assign issue_raw_instr        = issue_pkt.raw_instr;
  assign issue_instr_pc         = issue_pkt.instr_pc;
  assign issue_prn_input        = issue_pkt.prn_input;
  assign issue_prn_output_valid = issue_pkt.prn_output_valid;
  assign issue_prn_output       = issue_pkt.prn_output;

endmodule
